ahb_spi_master: RTL and testbench

- AHB-Lite slave that drives a single-slave, mode-0 SPI master. The SPI slave is the on-board accelerometer.
- Software controls chip select through a control bit.
- A write to the transmit register launches an 8-bit full-duplex transfer. The received byte is read back from a receive register.
- Sits on the system AHB-Lite bus behind the address decoder, alongside the other memory-mapped peripherals.

---
 rtl/ahb_spi_master_pkg.sv | 15 +
 rtl/ahb_spi_master_spi_shift_engine.sv | 62 ++++++
 rtl/ahb_spi_master.sv | 85 ++++++++
 tb/tb_ahb_spi_master.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ahb_spi_master_pkg.sv
// ahb_spi_master_pkg: register offsets, CTRL bit positions, HTRANS codes and SPI FSM states
package ahb_spi_master_pkg;
  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_TXDATA = 4'h4;
  localparam logic [3:0] OFS_RXDATA = 4'h8;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_DONE = 6;
  localparam int CTRL_BUSY = 7;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} spi_state_t;
endpackage

// File: rtl/ahb_spi_master_spi_shift_engine.sv
// spi_shift_engine: mode-0 MSB-first 8-bit shifter with SCLK divider and transfer FSM
module spi_shift_engine
  import ahb_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);
  spi_state_t state, state_nx;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr, rx_sr;
  logic        sclk_q, tick;
  assign tick = div_cnt == 16'(CLK_DIV - 1);
  assign SCLK = sclk_q;
  assign MOSI = tx_sr[7];
  assign rx_byte = rx_sr;
  always_comb begin
    state_nx = ST_IDLE;
    busy = state != ST_IDLE;
    rx_valid = state == ST_DONE;
    state_nx = state == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
               state == ST_SHIFT ? ((tick && sclk_q && bit_cnt == 3'd7) ? ST_DONE : ST_SHIFT) :
               ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  // rising SCLK samples MISO, falling SCLK advances MOSI
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      sclk_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      tx_sr <= tx_byte;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk_q <= 1'b0;
    end else if (state == ST_SHIFT) begin
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
      if (tick) begin
        sclk_q <= ~sclk_q;
        if (!sclk_q) rx_sr <= {rx_sr[6:0], MISO};
        else begin
          tx_sr <= {tx_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
endmodule

// File: rtl/ahb_spi_master.sv
// ahb_spi_master: AHB-Lite register front end for a mode-0 SPI master; define SPI_IRQ_EN for the done interrupt
module ahb_spi_master
  import ahb_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SCLK,
  output logic        ACCELEROMETER_SELECT_N
`ifdef SPI_IRQ_EN
  ,
  output logic        SPI_IRQ
`endif
);
  logic       phase_q, write_q, wr, ctrl_wr, start, busy, rx_valid, en, ie, done_f, unused;
  logic [1:0] addr_q;
  logic [3:0] ofs;
  logic [7:0] tx_data, rx_data, rx_byte, ctrl;
  assign HREADYOUT = 1'b1;
  assign ACCELEROMETER_SELECT_N = ~en;
  assign ofs = {addr_q, 2'b00};
  assign wr = phase_q & write_q;
  assign ctrl_wr = wr && ofs == OFS_CTRL;
  assign start = wr && ofs == OFS_TXDATA && !busy;
  assign ctrl = {busy, done_f, 4'b0000, ie, en};
  assign HRDATA = {24'h0, ofs == OFS_CTRL   ? ctrl :
                          ofs == OFS_TXDATA ? tx_data :
                          ofs == OFS_RXDATA ? rx_data : 8'h00};
  assign unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      phase_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      en <= 1'b0;
      tx_data <= '0;
      rx_data <= '0;
    end else begin
      phase_q <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        write_q <= HWRITE;
        addr_q <= HADDR[3:2];
      end
      if (ctrl_wr) en <= HWDATA[CTRL_EN];
      if (start) tx_data <= HWDATA[7:0];
      if (rx_valid) rx_data <= rx_byte;
    end
`ifdef SPI_IRQ_EN
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      ie <= 1'b0;
      done_f <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= HWDATA[CTRL_IE];
      done_f <= rx_valid | (done_f & ~(ctrl_wr & HWDATA[CTRL_DONE]));
    end
  assign SPI_IRQ = ie & done_f;
`else
  assign ie = 1'b0;
  assign done_f = 1'b0;
`endif
  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk(HCLK),
    .rst(HRESET),
    .start(start),
    .tx_byte(HWDATA[7:0]),
    .busy(busy),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .MISO(MISO)
  );
endmodule

// File: tb/tb_ahb_spi_master.sv
// tb_ahb_spi_master: directed bus sequence with a read-data scoreboard and SCLK/MOSI monitoring
module tb_ahb_spi_master;
  logic        HCLK, HRESET, HSEL, HREADY, HWRITE, HREADYOUT, MOSI, MISO, SCLK, cs_n;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        loop, miso_drv, sclk_prev;
  logic [7:0]  tx_pat, rx_pat;
  int          checks = 0, failures = 0, rises = 0, falls = 0, last_rise = 0, sclk_rises = 0, base;
  typedef struct { logic [31:0] exp; string tag; } exp_t;
  exp_t sb[$];
`ifdef SPI_IRQ_EN
  logic SPI_IRQ;
  localparam logic [31:0] DONE_RD = 32'h40;
`else
  localparam logic [31:0] DONE_RD = 32'h0;
`endif
  ahb_spi_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .MOSI(MOSI), .MISO(MISO), .SCLK(SCLK),
    .ACCELEROMETER_SELECT_N(cs_n)
`ifdef SPI_IRQ_EN
    , .SPI_IRQ(SPI_IRQ)
`endif
  );
  assign MISO = loop ? MOSI : miso_drv;
  initial HCLK = 1'b0;
  always #10 HCLK = ~HCLK;
  always @(posedge SCLK) sclk_rises++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
  endtask
  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    sb.push_back('{exp, tag});
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    e = sb.pop_front();
    check(e.tag, HRDATA, e.exp);
    check({e.tag, "_hreadyout"}, {31'b0, HREADYOUT}, 32'h1);
  endtask
  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HWDATA = '0; loop = 1'b0; miso_drv = 1'b0;
    repeat (3) @(negedge HCLK);
    check("rst_cs_n", {31'b0, cs_n}, 32'h1);
    check("rst_sclk", {31'b0, SCLK}, 32'h0);
    check("rst_mosi", {31'b0, MOSI}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    bus_read(32'h0, 32'h0, "rst_ctrl");
    bus_read(32'h4, 32'h0, "rst_tx");
    bus_read(32'h8, 32'h0, "rst_rx");
    bus_read(32'hC, 32'h0, "rst_reserved");
    bus_write(32'h0, 32'h1);
    bus_read(32'h0, 32'h1, "en_ctrl");
    check("en_cs_n", {31'b0, cs_n}, 32'h0);
    loop = 1'b1;
    bus_write(32'h4, 32'h16);
    bus_read(32'h4, 32'h16, "lb_tx");
    bus_read(32'h0, 32'h81, "lb_ctrl_busy");
    #3500;
    bus_read(32'h0, 32'h1 | DONE_RD, "lb_ctrl_done");
    bus_read(32'h8, 32'h16, "lb_rx");
    bus_write(32'h0, 32'h0);
    @(negedge HCLK);
    check("dis_cs_n", {31'b0, cs_n}, 32'h1);
    loop = 1'b0; tx_pat = 8'hA5; rx_pat = 8'h3C; miso_drv = rx_pat[7];
    sclk_prev = 1'b0;
    bus_write(32'h4, {24'h0, tx_pat});
    for (int c = 0; c < 200; c++) begin
      @(negedge HCLK);
      if (SCLK && !sclk_prev) begin
        if (rises < 8) check($sformatf("mosi_bit%0d", rises), {31'b0, MOSI}, {31'b0, tx_pat[7-rises]});
        if (rises > 0) check($sformatf("sclk_period%0d", rises), 32'(c - last_rise), 32'd16);
        last_rise = c;
        rises++;
      end
      if (!SCLK && sclk_prev) begin
        check($sformatf("sclk_high%0d", falls), 32'(c - last_rise), 32'd8);
        falls++;
        if (falls < 8) miso_drv = rx_pat[7-falls];
      end
      sclk_prev = SCLK;
    end
    check("a5_pulses", 32'(rises), 32'd8);
    bus_read(32'h8, 32'h3C, "a5_rx");
    loop = 1'b1;
    base = sclk_rises;
    bus_write(32'h4, 32'h16);
    bus_write(32'h4, 32'h55);
    bus_read(32'h4, 32'h16, "busy_tx_kept");
    repeat (250) @(negedge HCLK);
    check("busy_one_burst", 32'(sclk_rises - base), 32'd8);
    bus_read(32'h8, 32'h16, "busy_rx");
    bus_write(32'h0, 32'h1);
    bus_write(32'h4, 32'hFF);
    for (int c = 0; c < 40 && !SCLK; c++) @(negedge HCLK);
    check("pre_rst_sclk", {31'b0, SCLK}, 32'h1);
    check("pre_rst_cs_n", {31'b0, cs_n}, 32'h0);
    #3 HRESET = 1'b1;
    #1;
    check("mid_rst_sclk", {31'b0, SCLK}, 32'h0);
    check("mid_rst_cs_n", {31'b0, cs_n}, 32'h1);
    check("mid_rst_mosi", {31'b0, MOSI}, 32'h0);
    check("mid_rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    bus_read(32'h0, 32'h0, "post_rst_ctrl");
    bus_read(32'h4, 32'h0, "post_rst_tx");
    bus_read(32'h8, 32'h0, "post_rst_rx");
    repeat (20) @(negedge HCLK);
    check("post_rst_idle_sclk", {31'b0, SCLK}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
